// File: rtl/seq_decoder.sv
// Multi-cycle instruction sequencer: fetches an instruction (plus an optional immediate word),
// executes control flow and a return-address stack, and issues register/data-memory strobes.
module seq_decoder #(
  parameter int DATA_W    = 16,
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic [DATA_W-1:0] rddata,
  input  logic [DATA_W-1:0] rsdata,
  input  logic              jump,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              rd_wen,
  output logic [2:0]        giantmux_sel,
  output logic [DATA_W-1:0] instr_q,
  output logic [DATA_W-1:0] n_q,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              ras_err
);

  localparam int RP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = RP_W + 1;

  typedef enum logic [2:0] {FETCH, FETCH_N, EXEC, MEM_WAIT, HALT} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
  logic [RP_W-1:0]   ras_top_q;
  logic [CNT_W-1:0]  ras_cnt_q;
  logic              ras_err_q;
  logic              ras_push, ras_pop, ras_full, ras_empty;
  logic              dmem_req_c;
  logic [4:0]        op, fetch_op;
  logic              unused_ok;

  assign unused_ok = ^{rsdata, rddata};

  // Immediate flag is the opcode LSB, so it is folded into the opcode tests below.
  function automatic logic needs_n(input logic [4:0] o);
    return (o == 5'b00001) || (o == 5'b00101) || ((o[4:3] == 2'b01) && o[0]);
  endfunction

  assign op        = instr_q[DATA_W-1:DATA_W-5];
  assign fetch_op  = imem_rdata[DATA_W-1:DATA_W-5];
  assign ras_full  = (ras_cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_empty = (ras_cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    rd_wen       = 1'b0;
    giantmux_sel = 3'b000;
    dmem_req_c   = 1'b0;
    case (state_q)
      FETCH: if (imem_ack) begin
        pc_d    = pc_q + PC_W'(1);
        state_d = needs_n(fetch_op) ? FETCH_N : EXEC;
      end
      FETCH_N: if (imem_ack) begin
        pc_d    = pc_q + PC_W'(1);
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        casez (op)
          5'b00000: ;
          5'b00001: begin
            ras_push = 1'b1;
            pc_d     = n_q[PC_W-1:0];
          end
          5'b0001?: if (jump) pc_d = pc_q + PC_W'(instr_q[1:0]) + PC_W'(1);
          5'b00100: pc_d = rddata[PC_W-1:0];
          5'b00101: pc_d = n_q[PC_W-1:0];
          5'b010??, 5'b110?0: begin
            rd_wen       = 1'b1;
            giantmux_sel = 3'b100;
          end
          5'b0110?: begin
            rd_wen       = 1'b1;
            giantmux_sel = 3'b101;
          end
          5'b0111?: begin
            rd_wen       = 1'b1;
            giantmux_sel = {1'b0, op[0], 1'b0};
          end
          5'b100??: begin
            dmem_req_c = 1'b1;
            state_d    = MEM_WAIT;
          end
          5'b11100: begin
            ras_pop = 1'b1;
            pc_d    = ras_empty ? rddata[PC_W-1:0] : ras_mem[ras_top_q];
          end
          default: state_d = HALT;
        endcase
      end
      MEM_WAIT: begin
        dmem_req_c = 1'b1;
        if (dmem_ack) begin
          if (!op[1]) begin
            rd_wen       = 1'b1;
            giantmux_sel = 3'b110;
          end
          state_d = FETCH;
        end
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
  end

  // Fetch request is gated by rst_n so it drops the instant reset asserts.
  assign imem_req  = rst_n && ((state_q == FETCH) || (state_q == FETCH_N));
  assign imem_addr = imem_req ? pc_q : '0;
  assign dmem_req  = dmem_req_c;
  assign dmem_we   = dmem_req_c && op[1];
  assign halted    = (state_q == HALT);
  assign pc        = pc_q;
  assign ras_err   = ras_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      instr_q   <= '0;
      n_q       <= '0;
      ras_top_q <= '0;
      ras_cnt_q <= '0;
      ras_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == FETCH && imem_ack) instr_q <= imem_rdata;
      if (state_q == FETCH_N && imem_ack) n_q <= imem_rdata;
      // A push onto a full stack wraps the top pointer over the oldest entry.
      if (ras_push) begin
        ras_top_q <= ras_top_q + RP_W'(1);
        if (ras_full) ras_err_q <= 1'b1;
        else          ras_cnt_q <= ras_cnt_q + CNT_W'(1);
      end
      if (ras_pop) begin
        if (ras_empty) begin
          ras_err_q <= 1'b1;
        end else begin
          ras_top_q <= ras_top_q - RP_W'(1);
          ras_cnt_q <= ras_cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ras_top_q + RP_W'(1)] <= pc_q;
  end

endmodule

// File: tb/tb_seq_decoder.sv
// Directed bench for seq_decoder: fetch handshake, immediates, CMP skip, RAS overflow/underflow,
// load handshake, asynchronous reset mid-wait and PC wrap.
module tb_seq_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [15:0] imem_addr, imem_rdata = '0;
  logic [15:0] rddata = '0, rsdata = '0;
  logic        jump = 1'b0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic        rd_wen;
  logic [2:0]  giantmux_sel;
  logic [15:0] instr_q, n_q, pc;
  logic        halted, ras_err;

  int nvec = 0;
  int nerr = 0;

  localparam logic [15:0] NOP  = 16'h0000;
  localparam logic [15:0] CALL = 16'h0800;
  localparam logic [15:0] CMP2 = 16'h1002;
  localparam logic [15:0] JMPI = 16'h2800;
  localparam logic [15:0] ADDI = 16'h4800;
  localparam logic [15:0] LOAD = 16'h8000;
  localparam logic [15:0] RTN  = 16'hE000;
  localparam logic [15:0] STP  = 16'hF800;

  seq_decoder #(.DATA_W(16), .PC_W(16), .RAS_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rddata(rddata), .rsdata(rsdata), .jump(jump),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rd_wen(rd_wen), .giantmux_sel(giantmux_sel),
    .instr_q(instr_q), .n_q(n_q), .pc(pc), .halted(halted), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; jump = 1'b0; rddata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_flags", 32'({halted, ras_err, rd_wen, dmem_req}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", 32'(imem_addr), 32'd0);
  endtask

  // Answers one fetch after 'delay' wait cycles; returns at the negedge after the ack edge.
  task automatic serve(input string tag, input logic [15:0] addr, input logic [15:0] data,
                       input int delay);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 32'(imem_req), 32'd1);
    chk({tag, "_addr"}, 32'(imem_addr), 32'(addr));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, 32'({imem_req, imem_addr}), 32'({1'b1, addr}));
    end
    imem_rdata = data;
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic cmp_case(input logic j, input logic [15:0] target);
    do_reset();
    serve("cmp_jmpi", 16'h0000, JMPI, 0);
    serve("cmp_jmpn", 16'h0001, 16'h0004, 0);
    serve("cmp_fetch", 16'h0004, CMP2, 0);
    jump = j;
    @(negedge clk);
    jump = 1'b0;
    serve("cmp_target", target, NOP, 0);
  endtask

  initial begin
    // NOP then STP
    do_reset();
    serve("t1_nop", 16'h0000, NOP, 1);
    serve("t1_stp", 16'h0001, STP, 1);
    @(negedge clk);
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_pc", 32'(pc), 32'd2);
    repeat (3) @(negedge clk);
    chk("t1_frozen", 32'({halted, imem_req, pc}), 32'({1'b1, 1'b0, 16'd2}));

    // ADD immediate with slow immediate fetch
    do_reset();
    serve("t2_add", 16'h0000, ADDI, 0);
    serve("t2_n", 16'h0001, 16'h0005, 3);
    chk("t2_wen", 32'(rd_wen), 32'd1);
    chk("t2_sel", 32'(giantmux_sel), 32'd4);
    chk("t2_pc", 32'(pc), 32'd2);
    chk("t2_nq", 32'(n_q), 32'h0005);
    chk("t2_iq", 32'(instr_q), 32'(ADDI));
    @(negedge clk);
    chk("t2_wen_off", 32'(rd_wen), 32'd0);
    chk("t2_next", 32'({imem_req, imem_addr}), 32'({1'b1, 16'd2}));

    // CMP skip taken / not taken
    cmp_case(1'b1, 16'h0008);
    cmp_case(1'b0, 16'h0005);

    // RAS depth 2: three CALLs, three RTNs
    do_reset();
    rddata = 16'h0040;
    serve("c1", 16'h0000, CALL, 0);
    serve("c1n", 16'h0001, 16'h0010, 0);
    serve("c2", 16'h0010, CALL, 0);
    serve("c2n", 16'h0011, 16'h0020, 0);
    @(negedge clk);
    chk("c2_err", 32'(ras_err), 32'd0);
    serve("c3", 16'h0020, CALL, 0);
    serve("c3n", 16'h0021, 16'h0030, 0);
    @(negedge clk);
    chk("c3_err", 32'(ras_err), 32'd1);
    chk("c3_pc", 32'(pc), 32'h0030);
    serve("r1", 16'h0030, RTN, 0);
    serve("r2", 16'h0022, RTN, 0);
    serve("r3", 16'h0012, RTN, 0);
    serve("r3_tgt", 16'h0040, NOP, 0);
    chk("r_err_sticky", 32'(ras_err), 32'd1);

    // Load handshake, then reset while waiting
    do_reset();
    serve("ld1", 16'h0000, LOAD, 0);
    chk("ld1_req", 32'({dmem_req, dmem_we, rd_wen}), 32'({1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    chk("ld1_wait", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1;
    #1;
    chk("ld1_wb", 32'({rd_wen, giantmux_sel}), 32'({1'b1, 3'b110}));
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("ld1_done", 32'({dmem_req, imem_req, imem_addr}), 32'({1'b0, 1'b1, 16'd1}));
    serve("ld2", 16'h0001, LOAD, 0);
    repeat (2) @(negedge clk);
    chk("ld2_wait", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ld2_async", 32'({imem_req, dmem_req, dmem_we, rd_wen, halted, giantmux_sel}), 32'd0);
    chk("ld2_regs", 32'({pc, instr_q}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ld2_restart", 32'({imem_req, imem_addr}), 32'({1'b1, 16'd0}));

    // PC wrap at 0xFFFF
    do_reset();
    serve("w_jmpi", 16'h0000, JMPI, 0);
    serve("w_n", 16'h0001, 16'hFFFF, 0);
    serve("w_top", 16'hFFFF, NOP, 0);
    serve("w_wrap", 16'h0000, STP, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 Parameter DATA_W, 16, instruction/operand width; opcode is instr[DATA_W-1:DATA_W-5], immediate flag is instr[DATA_W-5].
REQ-002 Parameter PC_W, 16, program-counter and address width.
REQ-003 Parameter RAS_DEPTH, 8, return-address-stack entries (power of 2, >=2).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_addr  out  PC_W  fetch address.
REQ-008 imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
REQ-009 imem_rdata  in  DATA_W  fetched word.
REQ-010 rddata, rsdata  in  DATA_W each  register-file read ports.
REQ-011 jump  in  1  condition result for CMP, sampled in EXEC.
REQ-012 dmem_req  out  1  data memory request; dmem_we  out  1  write qualifier; dmem_ack  in  1  completion.
REQ-013 rd_wen  out  1  register write strobe; giantmux_sel  out  3  writeback source select.
REQ-014 instr_q  out  DATA_W  current instruction; n_q  out  DATA_W  current immediate word.
REQ-015 pc  out  PC_W  program counter; halted  out  1  STP reached; ras_err  out  1  sticky stack over/underflow.

Function
REQ-016 FSM states SHALL be FETCH, FETCH_N, EXEC, MEM_WAIT, HALT.
REQ-017 FETCH: imem_req=1, imem_addr=pc; on imem_ack latch instr_q, pc<=pc+1; go FETCH_N if instruction needs N, else EXEC.
REQ-018 Needs-N: CALL(00001), JMP I(00101), and ALU/MAS/MOV (0100x-0111x) with immediate flag=1.
REQ-019 FETCH_N: imem_req=1, imem_addr=pc; on imem_ack latch n_q, pc<=pc+1, go EXEC.
REQ-020 imem_req and imem_addr SHALL stay stable until imem_ack; no new request in the ack cycle's following state unless a fetch state.
REQ-021 EXEC lasts exactly one cycle; all strobes (rd_wen, dmem_req start) are single-cycle except dmem_req hold in REQ-028.
REQ-022 NOP(00000): no effect, next FETCH.
REQ-023 ALU class: ADD/SUB(010xx), LSL/LSR(110x0) giantmux_sel=100; MAS(0110x)=101; MOV(0111x)={0,imm,0}; rd_wen=1 in EXEC.
REQ-024 CMP(0001x): if jump=1, pc<=pc+instr[1:0]+1 (skip); else unchanged.
REQ-025 JMP R(00100): pc<=rddata[PC_W-1:0]; JMP I: pc<=n_q[PC_W-1:0].
REQ-026 CALL: push pc onto RAS, pc<=n_q; full stack overwrites oldest entry and sets ras_err.
REQ-027 RTN(11100): pop RAS into pc; empty stack uses rddata instead and sets ras_err.
REQ-028 MEM class(1000x load, 1001x store): dmem_req=1, dmem_we=opcode[1], go MEM_WAIT, hold request until dmem_ack; on ack for load rd_wen=1, giantmux_sel=110; then FETCH.
REQ-029 STP(11111) and every undefined opcode: go HALT; halted=1; pc frozen at STP address+1; HALT exits only by reset.
REQ-030 All pc arithmetic modulo 2^PC_W; 2^PC_W-1 + 1 wraps to 0.
REQ-031 ras_err remains set until reset.

Reset
REQ-032 rst_n=0 SHALL immediately force state FETCH-pending, pc=0, RAS empty, all outputs 0 (imem_req=0 during reset), including mid-fetch or mid-MEM_WAIT.
REQ-033 First imem_req=1 with imem_addr=0 in the first cycle after rst_n deasserts.

Verification
REQ-034 Reset, memory {0:NOP,1:STP}, ack 1 cycle later -> fetches addr 0,1; halted=1, pc=2.
REQ-035 ADD I at 0, N=0x0005 at 1, ack delayed 3 cycles -> addr held stable; rd_wen single pulse, giantmux_sel=100, pc=2.
REQ-036 CMP instr[1:0]=2 at 4, jump=1 -> next fetch addr 8; jump=0 -> addr 5.
REQ-037 RAS_DEPTH=2, three nested CALLs then three RTNs -> ras_err=1 after third CALL; third RTN returns to rddata.
REQ-038 Load with dmem_ack after 4 cycles, rst_n pulsed low during wait -> all outputs 0 asynchronously, restart fetch at 0.
REQ-039 JMP I N=0xFFFF then NOP -> fetch 0xFFFF, next fetch 0x0000.
